// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory access unit between the execute stage and a single-port RAM
//   that has no byte enables. It turns byte-addressed RISC-V loads and stores
//   (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Sub-word loads are
//   extracted and extended here. Sub-word stores use read-modify-write.
//
//   State | Meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; req_ready=1
//   LD    | RAM read of the load word; extracted value captured
//   ST    | SW write of the latched store data
//   RD    | RAM read for SB/SH; merged word captured
//   WR    | write of the merged word
//   ERR   | one-cycle error response; RAM untouched
//   RESP  | one-cycle good response
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (accept when both are high)
//   req_wr, req_funct3       store flag, RISC-V size/sign code
//   req_addr, req_wdata      byte address, store data (low lanes)
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion, load data, error flag
//   ram_addr, ram_wr_ena, ram_wr_data, ram_rd_data  RAM port (async read)
module load_store_unit #(
  parameter int W      = 32,
  parameter int L      = 128,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [W-1:0]         req_wdata,
  output logic                 rsp_valid,
  output logic [W-1:0]         rsp_rdata,
  output logic                 rsp_err,
  output logic [$clog2(L)-1:0] ram_addr,
  output logic                 ram_wr_ena,
  output logic [W-1:0]         ram_wr_data,
  input  logic [W-1:0]         ram_rd_data
);

  localparam int AW = $clog2(L);

  typedef enum logic [2:0] {
    S_IDLE, S_LD, S_ST, S_RD, S_WR, S_ERR, S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     funct3_q;
  logic [1:0]     off_q;
  logic [W-1:0]   wdata_q;
  logic [AW-1:0]  idx_q;
  logic [W-1:0]   rdata_q;
  logic [W-1:0]   merge_q;

  logic           accept;
  logic           req_illegal, req_misal, req_oor, req_err;
  logic [4:0]     shamt;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [W-1:0]   load_val;
  logic [W-1:0]   lane_mask, ins_val, merged;

  assign accept = req_valid && (state_q == S_IDLE);

  // Stores only have SB/SH/SW; loads reject 011, 110, 111.
  assign req_illegal = req_wr ? (req_funct3 > 3'd2)
                              : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign req_misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_oor     = |req_addr[ADDR_W-1:AW+2];
  assign req_err     = req_illegal || req_misal || req_oor;

  // Lane select: byte offset * 8; halfword loads are aligned so off_q[0]=0.
  assign shamt    = {off_q, 3'b000};
  assign lane_b   = 8'(ram_rd_data >> shamt);
  assign lane_h   = 16'(ram_rd_data >> shamt);

  always_comb begin
    load_val = ram_rd_data;
    case (funct3_q)
      3'b000:  load_val = {{(W-8){lane_b[7]}}, lane_b};
      3'b001:  load_val = {{(W-16){lane_h[15]}}, lane_h};
      3'b100:  load_val = {{(W-8){1'b0}}, lane_b};
      3'b101:  load_val = {{(W-16){1'b0}}, lane_h};
      default: load_val = ram_rd_data;
    endcase
  end

  // Read-modify-write: replace only the addressed lane, keep the rest bit-exact.
  assign lane_mask = funct3_q[0] ? W'(16'hFFFF) : W'(8'hFF);
  assign ins_val   = (wdata_q & lane_mask) << shamt;
  assign merged    = (ram_rd_data & ~(lane_mask << shamt)) | ins_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      merge_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata;
        idx_q    <= req_addr[AW+1:2];
        rdata_q  <= '0;
      end
      if (state_q == S_LD) rdata_q <= load_val;
      if (state_q == S_RD) merge_q <= merged;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                      state_d = S_ERR;
          else if (!req_wr)                 state_d = S_LD;
          else if (req_funct3[1:0] == 2'b10) state_d = S_ST;
          else                              state_d = S_RD;
        end
      end
      S_LD, S_ST, S_WR: state_d = S_RESP;
      S_RD:             state_d = S_WR;
      S_ERR, S_RESP:    state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == S_IDLE);
    rsp_valid   = (state_q == S_RESP) || (state_q == S_ERR);
    rsp_err     = (state_q == S_ERR);
    rsp_rdata   = (state_q == S_RESP) ? rdata_q : '0;
    ram_addr    = idx_q;
    ram_wr_ena  = (state_q == S_ST) || (state_q == S_WR);
    ram_wr_data = '0;
    if (state_q == S_ST) ram_wr_data = wdata_q;
    if (state_q == S_WR) ram_wr_data = merge_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [6:0]  ram_addr;
  logic        ram_wr_ena;
  logic [31:0] ram_wr_data, ram_rd_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram     [128];
  logic [31:0] ref_mem [128];
  int          wr_cnt = 0;
  logic [31:0] last_wr_data = '0;

  always #5 clk = ~clk;

  load_store_unit #(.W(32), .L(128), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wr_ena(ram_wr_ena), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  // Attached RAM: asynchronous read, synchronous write.
  assign ram_rd_data = ram[ram_addr];
  always @(posedge clk) if (ram_wr_ena) ram[ram_addr] <= ram_wr_data;

  always @(negedge clk) begin
    if (ram_wr_ena && !rst) begin
      wr_cnt++;
      last_wr_data = ram_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_err(bit wr, logic [2:0] f3, logic [31:0] a);
    bit ill;
    if (wr) ill = (f3 != 3'd0 && f3 != 3'd1 && f3 != 3'd2);
    else    ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (ill) return 1'b1;
    if (a >= 32'd512) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) return 1'b1;
    if (f3 == 3'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a);
    logic [31:0] w;
    int          off;
    logic [7:0]  b;
    logic [15:0] h;
    w   = ref_mem[a[8:2]];
    off = int'(a % 4);
    b   = 8'(w / (32'd1 << (8 * off)));
    h   = 16'(w / (32'd1 << (8 * off)));
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    logic [31:0] w, mask;
    int          off;
    w   = ref_mem[a[8:2]];
    off = int'(a % 4);
    if (f3 == 3'd2) return wd;
    mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  // Issue one request, check its response, and keep the reference memory in step.
  task automatic do_req(input string tag, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    bit          e;
    int          exp_lat, lat, n0, exp_wr;
    logic [31:0] exp_rd;
    e       = model_err(wr, f3, a);
    exp_rd  = (!e && !wr) ? model_load(f3, a) : 32'd0;
    exp_lat = e ? 1 : (!wr ? 2 : (f3 == 3'd2 ? 2 : 3));
    exp_wr  = (!e && wr) ? 1 : 0;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    n0 = wr_cnt;
    // Junk request held while busy must be ignored.
    req_wr = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_addr = $urandom_range(0, 511); req_wdata = $urandom;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = c; break; end
    end
    req_valid = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_ram_addr"}, {25'd0, ram_addr}, {23'd0, a[8:2]});
    chk({tag, "_writes"}, wr_cnt - n0, exp_wr);
    if (!e && wr) ref_mem[a[8:2]] = model_store(f3, a, wd);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int          lat, bad, seen;
    logic [31:0] saved;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;

    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 128; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[5] = 32'h8899_AABB; ref_mem[5] = 32'h8899_AABB;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_addr", {25'd0, ram_addr}, 32'd0);
    chk("rst_wr_ena", {31'd0, ram_wr_ena}, 32'd0);
    chk("rst_wr_data", ram_wr_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed: loads of word 5, sub-word store, errors.
    do_req("lb15",  1'b0, 3'd0, 32'h15, 32'd0);
    do_req("lbu15", 1'b0, 3'd4, 32'h15, 32'd0);
    do_req("lh16",  1'b0, 3'd1, 32'h16, 32'd0);
    do_req("lw14",  1'b0, 3'd2, 32'h14, 32'd0);
    do_req("sb17",  1'b1, 3'd0, 32'h17, 32'h0000_0042);
    chk("sb17_wdata", last_wr_data, 32'h4299_AABB);
    chk("sb17_word5", ram[5], 32'h4299_AABB);
    do_req("sw22",  1'b1, 3'd2, 32'h22, 32'h1234_5678);
    do_req("lw200", 1'b0, 3'd2, 32'h200, 32'd0);
    do_req("ld_ill", 1'b0, 3'd3, 32'h10, 32'd0);
    do_req("st_ill", 1'b1, 3'd4, 32'h10, 32'd0);

    // Reset during the write cycle of SH 0x14.
    saved = ram[5];
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_funct3 = 3'd1; req_addr = 32'h14; req_wdata = 32'hBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_wr", {31'd0, ram_wr_ena}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_wr_drop", {31'd0, ram_wr_ena}, 32'd0);
    chk("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("t5_no_rsp_after", seen, 0);
    chk("t5_ready", {31'd0, req_ready}, 32'd1);
    chk("t5_word5", ram[5], saved);

    // Back-to-back SW then LW with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_wr = 1'b0; req_wdata = 32'd0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = c; break; end
    end
    chk("b2b_sw_lat", lat, 2);
    ref_mem[4] = 32'hCAFE_F00D;
    @(negedge clk);
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = c; break; end
    end
    chk("b2b_lw_lat", lat, 2);
    chk("b2b_lw_data", rsp_rdata, 32'hCAFE_F00D);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      wr = $urandom_range(0, 1);
      f3 = 3'($urandom);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else                            a = $urandom_range(0, 511);
      do_req("rnd", wr, f3, a, $urandom);
    end

    bad = 0;
    for (int i = 0; i < 128; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("mem_final_bad_words", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
